// File: rtl/tag_ctrl_pkg.sv
// Shared types and default geometry for the tag array controller.
package tag_ctrl_pkg;

    localparam int unsigned TAG_WIDTH_DEF = 23;
    localparam int unsigned IDX_WIDTH_DEF = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        GNT_LK = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/tag_array_ctrl_if.sv
// Requester-side bundle: flush/init status, lookup channel and fill channel.
interface tag_array_ctrl_if
    import tag_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) ();

    logic                 flush;
    logic                 init_done;
    logic                 lk_req;
    logic [IDX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0] lk_tag;
    logic                 lk_gnt;
    logic                 lk_rvalid;
    logic [TAG_WIDTH-1:0] lk_rtag;
    logic                 lk_hit;
    logic                 wr_req;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic [TAG_WIDTH-1:0] wr_tag;
    logic                 wr_gnt;

    // Cache control side
    modport master (
        output flush, lk_req, lk_idx, lk_tag, wr_req, wr_idx, wr_tag,
        input  init_done, lk_gnt, lk_rvalid, lk_rtag, lk_hit, wr_gnt
    );

    // Tag array controller side
    modport slave (
        input  flush, lk_req, lk_idx, lk_tag, wr_req, wr_idx, wr_tag,
        output init_done, lk_gnt, lk_rvalid, lk_rtag, lk_hit, wr_gnt
    );

endinterface

// File: rtl/tag_array_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (lookup vs fill) for the shared SRAM port.
module rr_arb2
    import tag_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_lk_i,
    input  logic req_wr_i,
    output logic gnt_lk_o,
    output logic gnt_wr_o
);

    grant_e last_q, last_d;

    // Lone requester always wins; on contention grant the side that lost last time
    always_comb begin
        gnt_lk_o = 1'b0;
        gnt_wr_o = 1'b0;
        last_d   = last_q;
        if (en_i) begin
            if (req_lk_i && req_wr_i) begin
                if (last_q == GNT_WR) begin
                    gnt_lk_o = 1'b1;
                    last_d   = GNT_LK;
                end else begin
                    gnt_wr_o = 1'b1;
                    last_d   = GNT_WR;
                end
            end else begin
                gnt_lk_o = req_lk_i;
                gnt_wr_o = req_wr_i;
            end
        end
    end

    // History register, moves only on contention grants
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_WR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tag_array_ctrl.sv
// Tag SRAM sequencer: zero sweep after reset/flush, then lookup/fill arbitration
// onto a single-port RW macro with one-cycle lookup result latency.
module tag_array_ctrl
    import tag_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    tag_array_ctrl_if.slave      bus,
    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [IDX_WIDTH-1:0] sram_addr,
    output logic [TAG_WIDTH-1:0] sram_din,
    input  logic [TAG_WIDTH-1:0] sram_dout
);

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rvalid_q;
    logic [TAG_WIDTH-1:0] cap_tag_q;
    logic [IDX_WIDTH-1:0] addr_q;
    logic [TAG_WIDTH-1:0] din_q;
    logic                 arb_en;
    logic                 gnt_lk;
    logic                 gnt_wr;

    assign arb_en = (state_q == RUN) && !rst;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (arb_en),
        .req_lk_i (bus.lk_req),
        .req_wr_i (bus.wr_req),
        .gnt_lk_o (gnt_lk),
        .gnt_wr_o (gnt_wr)
    );

    // Next state and SRAM drive; idle cycles keep the last address/data on the bus
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = addr_q;
        sram_din  = din_q;
        if (!rst) begin
            case (state_q)
                INIT: begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = cnt_q;
                    sram_din  = '0;
                    cnt_d     = cnt_q + IDX_WIDTH'(1);
                    if (&cnt_q) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (gnt_wr) begin
                        sram_csb  = 1'b0;
                        sram_web  = 1'b0;
                        sram_addr = bus.wr_idx;
                        sram_din  = bus.wr_tag;
                    end else if (gnt_lk) begin
                        sram_csb  = 1'b0;
                        sram_addr = bus.lk_idx;
                    end
                    if (bus.flush) begin
                        state_d = INIT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, sweep counter, lookup pipeline and SRAM bus hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            cap_tag_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt_lk;
            if (gnt_lk) begin
                cap_tag_q <= bus.lk_tag;
            end
            addr_q <= sram_addr;
            din_q  <= sram_din;
        end
    end

    // Status outputs are forced to reset values while rst is held
    assign bus.init_done = (state_q == RUN) && !rst;
    assign bus.lk_gnt    = gnt_lk;
    assign bus.wr_gnt    = gnt_wr;
    assign bus.lk_rvalid = rvalid_q && !rst;
    assign bus.lk_rtag   = bus.lk_rvalid ? sram_dout : '0;
    assign bus.lk_hit    = bus.lk_rvalid && (sram_dout == cap_tag_q);

endmodule

// File: doc/tag_array_ctrl.md
Name: tag_array_ctrl

Overview:
- Sequencer/arbiter for one 32x23 single-port RW tag SRAM: csb/web active low, inputs registered at posedge, write and read data applied at the following negedge.
- Shares the single port between a lookup requester (read plus tag compare) and a fill requester (tag write).
- Zero-initialises every entry after reset and on flush.
- Sits between the cache control FSM and the tag SRAM macro; one instance per way.

Parameters:
- TAG_WIDTH, 23, tag/SRAM word width
- IDX_WIDTH, 5, set index width; depth = 2**IDX_WIDTH

Ports:
- clk  in  1  single clock; rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  one-cycle pulse; restart zero sweep
- init_done  out  1  high when sweep complete and requests accepted
- lk_req  in  1  lookup request; hold stable until lk_gnt
- lk_idx  in  IDX_WIDTH  lookup set index
- lk_tag  in  TAG_WIDTH  tag to compare
- lk_gnt  out  1  lookup issued this cycle
- lk_rvalid  out  1  lookup result valid (cycle after lk_gnt)
- lk_rtag  out  TAG_WIDTH  stored tag, valid with lk_rvalid
- lk_hit  out  1  lk_rtag == captured lk_tag, valid with lk_rvalid
- wr_req  in  1  fill request; hold stable until wr_gnt
- wr_idx  in  IDX_WIDTH  fill set index
- wr_tag  in  TAG_WIDTH  tag to write
- wr_gnt  out  1  write issued this cycle
- sram_csb  out  1  SRAM chip select, active low
- sram_web  out  1  SRAM write enable, active low
- sram_addr  out  IDX_WIDTH  SRAM address
- sram_din  out  TAG_WIDTH  SRAM write data
- sram_dout  in  TAG_WIDTH  SRAM read data

Behaviour:
- States: INIT, RUN. rst (any state, any cycle) -> INIT, cnt=0.
- Reset values: init_done=0, lk_gnt=0, wr_gnt=0, lk_rvalid=0, lk_hit=0, lk_rtag=0, last_grant=WR (so first contention goes to lookup). During rst: sram_csb=1, sram_web=1.
- INIT:
  - Every cycle: csb=0, web=0, addr=cnt, din=0; cnt++.
  - At cnt==31 -> RUN. Sweep is exactly 32 cycles; init_done rises the cycle after the last write.
  - lk_gnt=wr_gnt=0 throughout; requests wait.
- RUN, SRAM signals combinational from the arbitration decision in the same cycle:
  - Neither request: csb=1, web=1; addr and din hold their last values.
  - Only wr_req: wr_gnt=1, csb=0, web=0, addr=wr_idx, din=wr_tag.
  - Only lk_req: lk_gnt=1, csb=0, web=1, addr=lk_idx.
  - Both: grant the requester opposite to last_grant (round-robin). last_grant updates only on contention grants. No requester waits more than 1 cycle under continuous contention.
  - Exactly one grant per cycle; lk_gnt & wr_gnt never both 1.
- Lookup latency:
  - On lk_gnt in cycle N, capture lk_tag into a register.
  - Cycle N+1: lk_rvalid=1 for exactly one cycle, lk_rtag=sram_dout, lk_hit=(sram_dout==captured tag).
  - Back-to-back lookups give lk_rvalid on consecutive cycles (full throughput).
- Read-after-write, same index: write granted in N, lookup granted in N+1 -> the lookup returns the new tag (write lands at negedge of N+1, before the read at negedge of N+2). No bypass needed.
- Write then lookup of the same index requested in the same cycle: resolved by round-robin. If the lookup wins, it returns the old tag; this is the requester's responsibility.
- flush:
  - Accepted in RUN only; ignored in INIT.
  - Takes effect next cycle: state=INIT, cnt=0, init_done=0.
  - A request granted in the flush cycle completes normally, including its lk_rvalid.
  - flush and a request in the same cycle: the request is still granted that cycle.
- rst during INIT or with a lookup in flight: sweep restarts from 0 and the pending lk_rvalid is suppressed.
- cnt is IDX_WIDTH bits; wrap from 31 to 0 coincides with the INIT->RUN transition.

Decomposition:
- Shared package (tag_ctrl_pkg): state enum {INIT, RUN}, grant enum {GNT_LK, GNT_WR}, TAG_WIDTH/IDX_WIDTH defaults.
- Optional sub-module rr_arb2: 2-requester round-robin arbiter with last_grant register. Everything else flat.
- Bench instantiates the real SRAM model behind the sram_* ports.

Test Plan:
- Reset 1 cycle, then idle: 32 cycles of web=0 with addr 0..31 and din=0; init_done=1 on cycle 33; lookup idx 7 tag 0 -> lk_hit=1, lk_rtag=0.
- Write idx 3 tag 0x12345 (cycle N), lookup idx 3 tag 0x12345 (cycle N+1) -> lk_rvalid at N+2, lk_hit=1; lookup tag 0x12346 -> lk_hit=0, lk_rtag=0x12345.
- lk_req and wr_req both held 6 cycles -> grants alternate LK,WR,LK,WR,LK,WR; never both in one cycle.
- Lookups to idx 0,1,2 on consecutive cycles after writing tags 0xA, 0xB, 0xC -> lk_rvalid three consecutive cycles with lk_rtag 0xA, 0xB, 0xC.
- Write idx 5 tag 0x7FFFFF, pulse flush, wait for init_done, lookup idx 5 -> lk_rtag=0; no grants while init_done=0.
- Assert rst at sweep cnt=17 and again the cycle after a lk_gnt -> sweep restarts at addr 0; no lk_rvalid emitted; all outputs at reset values.
